// File: rtl/updown_cmd_gen.sv
// Purpose : turns raw up/down/clear pushbuttons into clean single-cycle 2-bit counter commands.
// Latency : input stable before edge N -> up_down valid for the one cycle after edge N+2+DEBOUNCE_CYCLES.
// Backpressure: none; the downstream counter consumes a command every cycle it is non-zero.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous, active-high
//   btn_up    raw up button (asynchronous, active-high)
//   btn_down  raw down button (asynchronous, active-high)
//   btn_clr   raw clear button (asynchronous, active-high)
//   up_down   registered command: 00 hold, 01 up, 10 down, 11 clear
//   btn_held  registered, high while a press is being held
//
// Optional build macro: UPDOWN_CMD_AUTO_REPEAT_EN enables hold-to-repeat for up/down.
module updown_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_clr,
    output logic [1:0] up_down,
    output logic       btn_held
);

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        ISSUE,
        HOLD,
        RELEASE
    } state_t;

    // Two-flop synchronizer, bit order {clr, up, down}.
    logic [2:0] sync1;
    logic [2:0] sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
        end else begin
            sync1 <= {btn_clr, btn_up, btn_down};
            sync2 <= sync1;
        end
    end

    // Clear dominates; up and down together cancel out.
    logic [1:0] req;
    always_comb begin
        req = 2'b00;
        if (sync2[2])
            req = 2'b11;
        else if (sync2[1] && !sync2[0])
            req = 2'b01;
        else if (sync2[0] && !sync2[1])
            req = 2'b10;
    end

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      cand;
    logic [1:0]      cand_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [CW-1:0]   cnt_inc;
    logic [1:0]      up_down_nxt;
    logic            btn_held_nxt;

    assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);

`ifdef UPDOWN_CMD_AUTO_REPEAT_EN
    localparam logic [CW-1:0] RPT_DELAY_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RPT_PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

    // rpt_cnt holds (edges since the last pulse) - 1, so a threshold of
    // LIMIT-1 places the next pulse exactly LIMIT cycles after the previous one.
    // rpt_rep is set once the first repeat has fired, switching to the period.
    logic [CW-1:0] rpt_cnt;
    logic [CW-1:0] rpt_cnt_nxt;
    logic [CW-1:0] rpt_inc;
    logic [CW-1:0] rpt_limit;
    logic          rpt_rep;
    logic          rpt_rep_nxt;

    assign rpt_inc = (rpt_cnt == {CW{1'b1}}) ? rpt_cnt : rpt_cnt + CW'(1);
`endif

    always_comb begin
        state_nxt   = state;
        cand_nxt    = cand;
        cnt_nxt     = cnt;
        up_down_nxt = 2'b00;
`ifdef UPDOWN_CMD_AUTO_REPEAT_EN
        rpt_cnt_nxt = '0;
        rpt_rep_nxt = 1'b0;
        rpt_limit   = rpt_rep ? RPT_PERIOD_LAST : RPT_DELAY_LAST;
`endif
        unique case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    cand_nxt  = req;
                    cnt_nxt   = '0;
                    state_nxt = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (req != cand) begin
                    state_nxt = IDLE;
                end else if (cnt >= DB_LAST) begin
                    state_nxt   = ISSUE;
                    up_down_nxt = cand;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ISSUE: begin
                state_nxt = HOLD;
                cnt_nxt   = '0;
`ifdef UPDOWN_CMD_AUTO_REPEAT_EN
                rpt_cnt_nxt = CW'(1);
`endif
            end
            HOLD: begin
                // Any change, even to another non-zero code, forces a release first.
                if (req != cand) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = '0;
                end
`ifdef UPDOWN_CMD_AUTO_REPEAT_EN
                else if (cand == 2'b01 || cand == 2'b10) begin
                    if (rpt_cnt >= rpt_limit) begin
                        up_down_nxt = cand;
                        rpt_cnt_nxt = '0;
                        rpt_rep_nxt = 1'b1;
                    end else begin
                        rpt_cnt_nxt = rpt_inc;
                        rpt_rep_nxt = rpt_rep;
                    end
                end
`endif
            end
            RELEASE: begin
                if (req == 2'b00) begin
                    if (cnt >= DB_LAST)
                        state_nxt = IDLE;
                    else
                        cnt_nxt = cnt_inc;
                end else if (req == cand) begin
                    // Bounce back onto the held button: resume without a new pulse.
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        btn_held_nxt = (state_nxt == HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cand     <= 2'b00;
            cnt      <= '0;
            up_down  <= 2'b00;
            btn_held <= 1'b0;
        end else begin
            state    <= state_nxt;
            cand     <= cand_nxt;
            cnt      <= cnt_nxt;
            up_down  <= up_down_nxt;
            btn_held <= btn_held_nxt;
        end
    end

`ifdef UPDOWN_CMD_AUTO_REPEAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_cnt <= '0;
            rpt_rep <= 1'b0;
        end else begin
            rpt_cnt <= rpt_cnt_nxt;
            rpt_rep <= rpt_rep_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_updown_cmd_gen.sv
// Purpose : scoreboard bench for updown_cmd_gen with directed button sequences.
// Latency : expected pulses are queued with their cycle number and matched on the falling edge.
// Backpressure: none.
module tb_updown_cmd_gen;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up;
    logic       btn_down;
    logic       btn_clr;
    logic [1:0] up_down;
    logic       btn_held;

    updown_cmd_gen #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(8),
        .REPEAT_PERIOD(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .btn_clr(btn_clr),
        .up_down(up_down),
        .btn_held(btn_held)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    bit done  = 1'b0;

    typedef struct {
        int         at;
        logic [1:0] code;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic expect_pulse(input int at, input logic [1:0] code);
        exp_t e;
        e.at   = at;
        e.code = code;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] got, input logic [1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: cyc=%0d got=%b required=%b", name, cyc, got, want);
        end
    endtask

    // Monitor: any non-zero command must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!done && !reset) begin
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                mon_e = exp_q.pop_front();
                total++;
                bad++;
                $display("FAIL pulse_missing: expected code=%b at cyc=%0d, not seen by cyc=%0d",
                         mon_e.code, mon_e.at, cyc);
            end
            if (up_down !== 2'b00) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL pulse_unexpected: cyc=%0d got=%b required=00", cyc, up_down);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.at != cyc || mon_e.code !== up_down) begin
                        bad++;
                        $display("FAIL pulse: got code=%b at cyc=%0d required code=%b at cyc=%0d",
                                 up_down, cyc, mon_e.code, mon_e.at);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int m;
        int p;
        logic [5:0] pat;

        // Reset held 2 edges with up pressed: outputs stay quiet.
        reset    = 1'b1;
        btn_up   = 1'b1;
        btn_down = 1'b0;
        btn_clr  = 1'b0;
        tick(1);
        check("rst_up_down_0", up_down, 2'b00);
        check("rst_held_0", {1'b0, btn_held}, 2'b00);
        tick(1);
        check("rst_up_down_1", up_down, 2'b00);
        check("rst_held_1", {1'b0, btn_held}, 2'b00);
        reset = 1'b0;
        // First unreset edge is 3; pulse after edge 3+2+D.
        expect_pulse(3 + 2 + D, 2'b01);
        tick(8);
        check("hold_held_hi", {1'b0, btn_held}, 2'b01);
        tick(22 - cyc);
        btn_up = 1'b0;
        m = cyc;
        tick(2);
        check("release_held_still_hi", {1'b0, btn_held}, 2'b01);
        tick(1);
        check("release_held_lo", {1'b0, btn_held}, 2'b00);
        // Back in IDLE exactly D edges into RELEASE; a press landing right after must pulse.
        tick(m + 5 - cyc);
        btn_up = 1'b1;
        expect_pulse(cyc + 3 + D, 2'b01);
        tick(9);
        btn_up = 1'b0;
        tick(12);

        // Bouncing down button: only the final stable press pulses.
        m   = cyc;
        pat = 6'b101101;
        expect_pulse(m + 5 + 3 + D, 2'b10);
        for (int i = 0; i < 6; i++) begin
            btn_down = pat[5-i];
            tick(1);
        end
        tick(m + 20 - cyc);
        check("bounce_held_hi", {1'b0, btn_held}, 2'b01);
        btn_down = 1'b0;
        tick(12);

        // Up and down together cancel; adding clear issues one clear.
        btn_up   = 1'b1;
        btn_down = 1'b1;
        tick(12);
        check("updown_no_hold", {1'b0, btn_held}, 2'b00);
        btn_clr = 1'b1;
        expect_pulse(cyc + 3 + D, 2'b11);
        tick(10);
        check("clr_held_hi", {1'b0, btn_held}, 2'b01);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_clr  = 1'b0;
        tick(12);

        // Clear added while up is held: leaves HOLD, no clear pulse.
        btn_up = 1'b1;
        expect_pulse(cyc + 3 + D, 2'b01);
        tick(10);
        btn_clr = 1'b1;
        tick(2);
        check("clr_in_hold_still_hi", {1'b0, btn_held}, 2'b01);
        tick(1);
        check("clr_in_hold_lo", {1'b0, btn_held}, 2'b00);
        tick(8);
        btn_up  = 1'b0;
        btn_clr = 1'b0;
        tick(12);
        btn_clr = 1'b1;
        expect_pulse(cyc + 3 + D, 2'b11);
        tick(10);
        btn_clr = 1'b0;
        tick(12);

        // Long hold on up: repeats only when the feature is built in.
        m = cyc;
        p = m + 3 + D;
        btn_up = 1'b1;
        expect_pulse(p, 2'b01);
`ifdef UPDOWN_CMD_AUTO_REPEAT_EN
        for (int k = 8; k <= 28; k += 4)
            expect_pulse(p + k, 2'b01);
`endif
        tick(p + 28 - cyc);
        btn_up = 1'b0;
        tick(12);

        // Long hold on clear: never repeats.
        btn_clr = 1'b1;
        expect_pulse(cyc + 3 + D, 2'b11);
        tick(37);
        btn_clr = 1'b0;
        tick(12);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d expected pulses left, required 0", exp_q.size());
        end
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
